// File: rtl/jtkiwi_romrq_if.sv
// Kiwi ROM request bundle: three client read ports, the download flag and the shared SDRAM read port.
// "master" is the arbiter/cache side; "slave" is the game core and SDRAM controller side.
interface jtkiwi_romrq_if;
  logic        downloading;

  logic        main_cs;
  logic [16:0] main_addr;
  logic [7:0]  main_data;
  logic        main_ok;

  logic        sub_cs;
  logic [15:0] sub_addr;
  logic [7:0]  sub_data;
  logic        sub_ok;

  logic        gfx_cs;
  logic [19:0] gfx_addr;
  logic [31:0] gfx_data;
  logic        gfx_ok;

  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;

  modport master (
    input  downloading,
    input  main_cs, main_addr,
    output main_data, main_ok,
    input  sub_cs, sub_addr,
    output sub_data, sub_ok,
    input  gfx_cs, gfx_addr,
    output gfx_data, gfx_ok,
    output sdram_req, sdram_addr,
    input  sdram_ack, data_rdy, data_read
  );

  modport slave (
    output downloading,
    output main_cs, main_addr,
    input  main_data, main_ok,
    output sub_cs, sub_addr,
    input  sub_data, sub_ok,
    output gfx_cs, gfx_addr,
    input  gfx_data, gfx_ok,
    input  sdram_req, sdram_addr,
    output sdram_ack, data_rdy, data_read
  );
endinterface

// File: rtl/jtkiwi_romrq.sv
// Kiwi ROM request arbiter: one 32-bit line cache per client (main, sub, gfx) in front of a
// single SDRAM read port, with fixed priority gfx > main > sub on misses.
module jtkiwi_romrq #(
  parameter logic [21:0] MAIN_OFFSET = 22'h00000,
  parameter logic [21:0] SUB_OFFSET  = 22'h10000,
  parameter logic [21:0] GFX_OFFSET  = 22'h18000
) (
  input  logic              clk,
  input  logic              rst,
  jtkiwi_romrq_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CL_MAIN = 2'd0,
    CL_SUB  = 2'd1,
    CL_GFX  = 2'd2
  } client_t;

  function automatic logic [7:0] byte_sel(input logic [31:0] line, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = line[7:0];
      2'd1:    b = line[15:8];
      2'd2:    b = line[23:16];
      default: b = line[31:24];
    endcase
    return b;
  endfunction

  state_t      state, state_nx;
  client_t     client_lat, client_nx;
  logic [19:0] tag_lat, tag_nx;
  logic [21:0] addr_lat, addr_nx;

  logic        main_valid, sub_valid, gfx_valid;
  logic [14:0] main_tag_q;
  logic [13:0] sub_tag_q;
  logic [19:0] gfx_tag_q;
  logic [31:0] main_line, sub_line, gfx_line;

  logic [14:0] main_tag;
  logic [13:0] sub_tag;
  logic [19:0] gfx_tag;
  logic        main_hit, sub_hit, gfx_hit;
  logic        main_miss, sub_miss, gfx_miss, any_miss;
  logic        start, fill, req;

  // Stage p0: tag compare against the current client addresses
  always_comb begin
    main_tag  = bus.main_addr[16:2];
    sub_tag   = bus.sub_addr[15:2];
    gfx_tag   = bus.gfx_addr;
    main_hit  = bus.main_cs & main_valid & (main_tag == main_tag_q);
    sub_hit   = bus.sub_cs  & sub_valid  & (sub_tag  == sub_tag_q);
    gfx_hit   = bus.gfx_cs  & gfx_valid  & (gfx_tag  == gfx_tag_q);
    main_miss = bus.main_cs & ~main_hit;
    sub_miss  = bus.sub_cs  & ~sub_hit;
    gfx_miss  = bus.gfx_cs  & ~gfx_hit;
    any_miss  = main_miss | sub_miss | gfx_miss;
  end

  always_comb begin
    client_nx = CL_MAIN;
    tag_nx    = '0;
    addr_nx   = '0;
    if (gfx_miss) begin
      client_nx = CL_GFX;
      tag_nx    = gfx_tag;
      addr_nx   = GFX_OFFSET + 22'({gfx_tag, 1'b0});
    end else if (main_miss) begin
      client_nx = CL_MAIN;
      tag_nx    = 20'(main_tag);
      addr_nx   = MAIN_OFFSET + 22'({main_tag, 1'b0});
    end else if (sub_miss) begin
      client_nx = CL_SUB;
      tag_nx    = 20'(sub_tag);
      addr_nx   = SUB_OFFSET + 22'({sub_tag, 1'b0});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!bus.downloading && any_miss) state_nx = WAIT_ACK;
      WAIT_ACK:  if (bus.sdram_ack) state_nx = bus.data_rdy ? IDLE : WAIT_DATA;
      WAIT_DATA: if (bus.data_rdy)  state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Data may arrive together with the ack, so a fill can complete straight from WAIT_ACK
  always_comb begin
    req   = 1'b0;
    start = 1'b0;
    fill  = 1'b0;
    case (state)
      IDLE:      start = !bus.downloading && any_miss;
      WAIT_ACK: begin
        req  = 1'b1;
        fill = bus.sdram_ack & bus.data_rdy;
      end
      WAIT_DATA: fill = bus.data_rdy;
      default:   ;
    endcase
  end

  assign bus.sdram_req  = req;
  assign bus.sdram_addr = addr_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      client_lat <= CL_MAIN;
      tag_lat    <= '0;
      addr_lat   <= '0;
    end else if (start) begin
      client_lat <= client_nx;
      tag_lat    <= tag_nx;
      addr_lat   <= addr_nx;
    end
  end

  // Download wipes every entry; a fill racing with it keeps its data but stays invalid
  always_ff @(posedge clk) begin
    if (rst || bus.downloading) begin
      main_valid <= 1'b0;
      sub_valid  <= 1'b0;
      gfx_valid  <= 1'b0;
    end else if (fill) begin
      case (client_lat)
        CL_MAIN: begin main_valid <= 1'b1; main_tag_q <= tag_lat[14:0]; end
        CL_SUB:  begin sub_valid  <= 1'b1; sub_tag_q  <= tag_lat[13:0]; end
        CL_GFX:  begin gfx_valid  <= 1'b1; gfx_tag_q  <= tag_lat;       end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      case (client_lat)
        CL_MAIN: main_line <= bus.data_read;
        CL_SUB:  sub_line  <= bus.data_read;
        CL_GFX:  gfx_line  <= bus.data_read;
        default: ;
      endcase
    end
  end

  // Stage p1: registered ok/data toward the clients
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.main_ok   <= 1'b0;
      bus.sub_ok    <= 1'b0;
      bus.gfx_ok    <= 1'b0;
      bus.main_data <= '0;
      bus.sub_data  <= '0;
      bus.gfx_data  <= '0;
    end else begin
      bus.main_ok <= main_hit & ~bus.downloading;
      bus.sub_ok  <= sub_hit  & ~bus.downloading;
      bus.gfx_ok  <= gfx_hit  & ~bus.downloading;
      if (main_hit) bus.main_data <= byte_sel(main_line, bus.main_addr[1:0]);
      if (sub_hit)  bus.sub_data  <= byte_sel(sub_line,  bus.sub_addr[1:0]);
      if (gfx_hit)  bus.gfx_data  <= gfx_line;
    end
  end

endmodule

// File: doc/jtkiwi_romrq.md
Name: jtkiwi_romrq

Overview:
- Sits directly downstream of the Kiwi game top. Consumes its three ROM request buses (main, sub, gfx) and returns data and ok for each.
- Arbitrates the three clients onto a single SDRAM read port.
- Holds a one-entry, 32-bit line cache per client, so repeated reads within a line are served without new SDRAM traffic.
- Runs on the SDRAM/system clock domain.

Parameters:
- MAIN_OFFSET, 22'h00000, SDRAM 16-bit-word base of main CPU ROM
- SUB_OFFSET, 22'h10000, SDRAM word base of sub CPU ROM
- GFX_OFFSET, 22'h18000, SDRAM word base of graphics ROM

Ports:
- clk  in  1  system clock; sole clock
- rst  in  1  synchronous, active-high reset
- downloading  in  1  ROM download in progress; blocks requests
- main_cs  in  1  main client request
- main_addr  in  17  main byte address
- main_data  out  8  main read byte
- main_ok  out  1  main data valid
- sub_cs  in  1  sub client request
- sub_addr  in  16  sub byte address
- sub_data  out  8  sub read byte
- sub_ok  out  1  sub data valid
- gfx_cs  in  1  gfx client request
- gfx_addr  in  20  gfx 32-bit word address
- gfx_data  out  32  gfx read word
- gfx_ok  out  1  gfx data valid
- sdram_req  out  1  read request
- sdram_addr  out  22  SDRAM 16-bit-word address
- sdram_ack  in  1  request accepted (1-cycle pulse)
- data_rdy  in  1  data_read valid (1-cycle pulse)
- data_read  in  32  two consecutive SDRAM words; low word = lower address

Behaviour:
- Reset (sync, rst=1):
  - all *_ok=0; all *_data=0
  - sdram_req=0; sdram_addr=0
  - all cache valid bits=0; FSM=IDLE
  - Applies mid-transaction too: any pending sdram_ack/data_rdy after reset is ignored.
- Cache tags:
  - main tag = main_addr[16:2]; sub tag = sub_addr[15:2]; gfx tag = gfx_addr.
  - Each cache entry holds {valid, tag, 32-bit line}.
  - hit_x = x_cs & valid_x & (tag_x == stored tag_x).
- Outputs (registered, 1-cycle latency):
  - Every cycle: x_ok <= hit_x. When hit, x_data <= selected data.
  - main/sub byte select: addr[1:0]=0 -> line[7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
  - gfx_data <= full line.
  - x_ok in cycle n+1 refers to the address sampled in cycle n. Clients hold the address until ok.
  - x_cs=0 -> x_ok=0 next cycle; x_data holds its last value.
- SDRAM address:
  - main: MAIN_OFFSET + {main_addr[16:2],1'b0}
  - sub: SUB_OFFSET + {sub_addr[15:2],1'b0}
  - gfx: GFX_OFFSET + {gfx_addr,1'b0}
  - 22-bit add, wraps modulo 2^22 with no error.
- FSM:
  - IDLE:
    - If !downloading and any miss (x_cs & !hit_x), pick one with fixed priority gfx > main > sub.
    - Latch client id and tag, drive sdram_addr, set sdram_req=1, go WAIT_ACK.
  - WAIT_ACK: hold sdram_req and sdram_addr. On sdram_ack: sdram_req=0, go WAIT_DATA.
  - WAIT_DATA: on data_rdy, write data_read to the latched client's line, store the latched tag, set valid, go IDLE.
  - The first hit-derived ok can appear 1 cycle after the write. Min miss-to-ok = 1 (req) + ack wait + data wait + 2 cycles.
- Boundary cases:
  - Client drops cs or changes address mid-transaction: the transaction completes and fills the cache with the latched tag. The new address then misses and re-arbitrates.
  - sdram_ack and data_rdy in the same cycle while in WAIT_ACK: accept both, fill the cache, go IDLE.
  - data_rdy seen in IDLE: ignored.
  - Multiple misses: losers wait in IDLE for the next arbitration. Starvation of sub is accepted (gfx bounded by video timing).
  - downloading=1:
    - Clears all valid bits every cycle and forces every *_ok=0 next cycle.
    - No new request is issued.
    - An in-flight transaction completes its handshake but does not set valid.
- No write path; ROM is read-only.

Test Plan:
- Reset then main_cs=1, main_addr=17'h00005:
  - sdram_req rises with sdram_addr=22'h000002.
  - Ack 2 cycles later; data_rdy 3 cycles after ack with data_read=32'hDDCCBBAA.
  - main_data=8'hBB, main_ok=1 one cycle after the fill.
- After that fill, main_addr=17'h00007:
  - No sdram_req; main_ok=1 next cycle, main_data=8'hDD.
- Same cycle main_cs (addr 0x100), sub_cs (addr 0x40), gfx_cs (addr 20'h00010), all misses:
  - Requests issue in order sdram_addr=22'h018020, then 22'h000080, then 22'h010020.
  - Each ok rises only after its own fill.
- main_addr changes from 0x10 to 0x20 during WAIT_DATA:
  - Cache filled for tag 0x4; then a new request at sdram_addr=22'h000010.
  - main_ok=1 only after the second fill.
- downloading pulsed for 1 cycle after valid fills:
  - All ok=0 the next cycle; re-reads of the previous addresses issue fresh sdram_req.
- rst asserted in WAIT_DATA, then data_rdy:
  - sdram_req=0, no cache write, main_ok stays 0; the next main_cs causes a fresh request.
